ddr4_dev_resp: RTL and testbench

Behavioural-synthesizable DDR4 device responder. It sits on the device side of the `ddr4_cont` command/data pins and closes the loop for controller simulation and FPGA loopback. It decodes ACT/RD/WR/PRE/REF/MRS, tracks open rows for 16 banks, and stores write bursts in an internal nibble array. It returns read bursts on DQ/DQS after a fixed CAS latency.

---
 rtl/ddr4_dev_resp.sv | 220 ++++++++++++++++++++++
 tb/tb_ddr4_dev_resp.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_dev_resp.sv
// DDR4 device-side responder: decodes controller commands, tracks open rows per bank,
// stores write bursts in a nibble array and replays them as BL8 read bursts after CL.
module ddr4_dev_resp #(
    parameter int CL       = 11,
    parameter int CWL      = 9,
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 6
) (
    input  logic        clkin,
    input  logic        crst,
    input  logic        drst_n,
    input  logic        cke,
    input  logic        dcs_n,
    input  logic        dact_n,
    input  logic [16:0] da,
    input  logic [1:0]  dbg,
    input  logic [1:0]  dba,
    input  logic [3:0]  ddq_i,
    output logic [3:0]  ddq_o,
    output logic        ddq_oe,
    output logic        ddqs_t_o,
    output logic        ddqs_c_o,
    output logic        ddqs_oe,
    output logic [15:0] bank_open,
    output logic        err_cmd
);

    localparam int CB = COL_BITS - 3;
    localparam int AW = 4 + ROW_BITS + COL_BITS;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_RD  = 3'd1;
    localparam logic [2:0] S_PRE_RD   = 3'd2;
    localparam logic [2:0] S_BURST_RD = 3'd3;
    localparam logic [2:0] S_WAIT_WR  = 3'd4;
    localparam logic [2:0] S_BURST_WR = 3'd5;

    localparam logic [2:0] C_MRS = 3'b000;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_NOP = 3'b111;

    logic [3:0]          mem [0:(1<<AW)-1];
    logic [ROW_BITS-1:0] row_q [0:15];

    logic [2:0]          state;
    logic [4:0]          cnt;
    logic [3:0]          bcnt;
    logic [3:0]          bank_l;
    logic [ROW_BITS-1:0] row_l;
    logic [CB-1:0]       col_l;
    logic                ap_l;

    logic [3:0]  bidx;
    logic        step;
    logic        cmd_vld;
    logic        burst_end;
    logic        eng_free;
    logic        mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0] open_eff;
    logic [15:0] open_nx;
    logic        is_act, is_ref, is_pre, is_rd, is_wr, is_bad;
    logic        acc_rd, acc_wr, err_nx;
    logic        da_unused;

    assign bidx      = {dbg, dba};
    assign step      = cke & drst_n;
    assign cmd_vld   = ~dcs_n & step;
    assign burst_end = step & ((state == S_BURST_RD) | (state == S_BURST_WR)) & (bcnt == 4'd8);
    assign eng_free  = (state == S_IDLE) | burst_end;
    assign mem_addr  = {bank_l, row_l, col_l, bcnt[2:0]};
    assign mem_we    = step & (((state == S_WAIT_WR) & (cnt == 5'd1)) |
                               ((state == S_BURST_WR) & (bcnt != 4'd8)));
    assign da_unused = ^da;

    // A burst-end auto-precharge is applied before the same-edge command is judged
    always_comb begin
        open_eff = bank_open;
        if (burst_end && ap_l)
            open_eff[bank_l] = 1'b0;

        is_act = 1'b0;
        is_ref = 1'b0;
        is_pre = 1'b0;
        is_rd  = 1'b0;
        is_wr  = 1'b0;
        is_bad = 1'b0;
        if (cmd_vld) begin
            if (!dact_n)
                is_act = 1'b1;
            else begin
                case (da[16:14])
                    C_MRS, C_NOP: is_bad = 1'b0;
                    C_REF:        is_ref = 1'b1;
                    C_PRE:        is_pre = 1'b1;
                    C_WR:         is_wr  = 1'b1;
                    C_RD:         is_rd  = 1'b1;
                    default:      is_bad = 1'b1;
                endcase
            end
        end

        acc_rd = is_rd & open_eff[bidx] & eng_free;
        acc_wr = is_wr & open_eff[bidx] & eng_free;
        err_nx = is_bad | (is_act & open_eff[bidx]) | (is_ref & (|open_eff)) |
                 ((is_rd | is_wr) & ~(open_eff[bidx] & eng_free));

        open_nx = open_eff;
        if (is_act)
            open_nx[bidx] = 1'b1;
        if (is_pre) begin
            if (da[10])
                open_nx = '0;
            else
                open_nx[bidx] = 1'b0;
        end
    end

    always_ff @(posedge clkin or posedge crst) begin
        if (crst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bcnt      <= '0;
            bank_open <= '0;
            err_cmd   <= 1'b0;
            ddq_o     <= '0;
            ddq_oe    <= 1'b0;
            ddqs_t_o  <= 1'b0;
            ddqs_c_o  <= 1'b1;
            ddqs_oe   <= 1'b0;
        end else if (!drst_n) begin
            state     <= S_IDLE;
            bank_open <= '0;
            err_cmd   <= 1'b0;
            ddq_oe    <= 1'b0;
            ddqs_t_o  <= 1'b0;
            ddqs_c_o  <= 1'b1;
            ddqs_oe   <= 1'b0;
        end else if (!cke) begin
            err_cmd <= 1'b0;
        end else begin
            bank_open <= open_nx;
            err_cmd   <= err_nx;
            case (state)
                S_WAIT_RD: begin
                    if (cnt == 5'd1) begin
                        state    <= S_PRE_RD;
                        ddqs_oe  <= 1'b1;
                        ddqs_t_o <= 1'b0;
                        ddqs_c_o <= 1'b1;
                    end else
                        cnt <= cnt - 5'd1;
                end
                S_PRE_RD: begin
                    state    <= S_BURST_RD;
                    bcnt     <= 4'd1;
                    ddq_o    <= mem[mem_addr];
                    ddq_oe   <= 1'b1;
                    ddqs_t_o <= 1'b1;
                    ddqs_c_o <= 1'b0;
                end
                S_BURST_RD: begin
                    if (bcnt == 4'd8) begin
                        state    <= S_IDLE;
                        ddq_oe   <= 1'b0;
                        ddqs_oe  <= 1'b0;
                        ddqs_t_o <= 1'b0;
                        ddqs_c_o <= 1'b1;
                    end else begin
                        bcnt     <= bcnt + 4'd1;
                        ddq_o    <= mem[mem_addr];
                        ddqs_t_o <= ~bcnt[0];
                        ddqs_c_o <= bcnt[0];
                    end
                end
                S_WAIT_WR: begin
                    if (cnt == 5'd1) begin
                        state <= S_BURST_WR;
                        bcnt  <= 4'd1;
                    end else
                        cnt <= cnt - 5'd1;
                end
                S_BURST_WR: begin
                    if (bcnt == 4'd8)
                        state <= S_IDLE;
                    else
                        bcnt <= bcnt + 4'd1;
                end
                default: state <= S_IDLE;
            endcase
            if (acc_rd) begin
                state <= S_WAIT_RD;
                cnt   <= 5'(CL - 1);
                bcnt  <= '0;
            end else if (acc_wr) begin
                state <= S_WAIT_WR;
                cnt   <= 5'(CWL);
                bcnt  <= '0;
            end
        end
    end

    // Row table, burst address latch and array survive every reset
    always_ff @(posedge clkin) begin
        if (acc_rd || acc_wr) begin
            bank_l <= bidx;
            row_l  <= row_q[bidx];
            col_l  <= da[COL_BITS-1:3];
            ap_l   <= da[10];
        end
        if (is_act && !open_eff[bidx])
            row_q[bidx] <= da[ROW_BITS-1:0];
        if (mem_we)
            mem[mem_addr] <= ddq_i;
    end

endmodule

// File: tb/tb_ddr4_dev_resp.sv
// Scoreboard bench for ddr4_dev_resp: a command-level timing model predicts bank flags,
// error pulses and read beats; a negedge monitor compares them against the pins.
module tb_ddr4_dev_resp;

    localparam int CL  = 11;
    localparam int CWL = 9;
    localparam int RB  = 4;
    localparam int CB  = 6;

    logic        clkin = 1'b0;
    logic        crst, drst_n, cke, dcs_n, dact_n;
    logic [16:0] da;
    logic [1:0]  dbg, dba;
    logic [3:0]  ddq_i;
    logic [3:0]  ddq_o;
    logic        ddq_oe, ddqs_t_o, ddqs_c_o, ddqs_oe, err_cmd;
    logic [15:0] bank_open;

    ddr4_dev_resp #(.CL(CL), .CWL(CWL), .ROW_BITS(RB), .COL_BITS(CB)) dut (
        .clkin(clkin), .crst(crst), .drst_n(drst_n), .cke(cke), .dcs_n(dcs_n),
        .dact_n(dact_n), .da(da), .dbg(dbg), .dba(dba), .ddq_i(ddq_i),
        .ddq_o(ddq_o), .ddq_oe(ddq_oe), .ddqs_t_o(ddqs_t_o), .ddqs_c_o(ddqs_c_o),
        .ddqs_oe(ddqs_oe), .bank_open(bank_open), .err_cmd(err_cmd)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        int       cyc;
        bit       pre;
        bit       chk;
        logic [3:0] d;
        bit       t;
    } beat_t;

    beat_t       exp_q[$];
    logic [3:0]  dq_q[$];
    logic [3:0]  m_mem[int];
    int          m_row[16];
    logic [15:0] m_open = '0;
    bit          m_busy = 0, m_wr = 0, m_ap = 0;
    int          m_bank, m_base, m_end, m_wstart;
    bit          exp_err = 0, frozen = 0, mon_en = 0;
    int          cyc = 0, errors = 0, checks = 0;

    function automatic int key(int b, int r, int c, int i);
        return ((b * (1 << RB) + r) * (1 << (CB - 3)) + c) * 8 + i;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    task automatic model_reset();
        m_open  = '0;
        m_busy  = 0;
        exp_err = 0;
        frozen  = 0;
        exp_q.delete();
    endtask

    task automatic start_burst(int t, int b, bit is_rd);
        beat_t e;
        m_busy = 1;
        m_bank = b;
        m_ap   = da[10];
        m_base = key(b, m_row[b], int'(da[CB-1:3]), 0);
        if (is_rd) begin
            m_wr  = 0;
            m_end = t + CL + 8;
            e.cyc = t + CL - 1; e.pre = 1; e.chk = 0; e.d = 0; e.t = 0;
            exp_q.push_back(e);
            for (int i = 0; i < 8; i++) begin
                e.cyc = t + CL + i;
                e.pre = 0;
                e.chk = m_mem.exists(m_base + i);
                e.d   = e.chk ? m_mem[m_base + i] : 4'h0;
                e.t   = (i % 2 == 0);
                exp_q.push_back(e);
            end
        end else begin
            m_wr     = 1;
            m_wstart = t + CWL;
            m_end    = t + CWL + 8;
        end
    endtask

    // Reference model evaluated on every rising edge from the sampled pins
    task automatic model_step(int t);
        int b;
        frozen  = 0;
        exp_err = 0;
        if (crst) begin
            model_reset();
            return;
        end
        if (!drst_n) begin
            m_open = '0;
            m_busy = 0;
            exp_q.delete();
            return;
        end
        if (!cke) begin
            frozen = 1;
            if (m_busy) begin
                m_end++;
                m_wstart++;
                foreach (exp_q[i]) if (exp_q[i].cyc >= t) exp_q[i].cyc++;
            end
            return;
        end
        if (m_busy && t == m_end) begin
            if (m_ap) m_open[m_bank] = 1'b0;
            m_busy = 0;
        end
        if (m_busy && m_wr && t >= m_wstart && t < m_wstart + 8)
            m_mem[m_base + t - m_wstart] = ddq_i;
        if (!dcs_n) begin
            b = int'({dbg, dba});
            if (!dact_n) begin
                if (m_open[b]) exp_err = 1;
                else begin
                    m_open[b] = 1'b1;
                    m_row[b]  = int'(da[RB-1:0]);
                end
            end else begin
                case (da[16:14])
                    3'b000, 3'b111: ;
                    3'b001: if (m_open != 0) exp_err = 1;
                    3'b010: if (da[10]) m_open = '0; else m_open[b] = 1'b0;
                    3'b100, 3'b101: begin
                        if (!m_open[b] || m_busy) exp_err = 1;
                        else start_burst(t, b, da[16:14] == 3'b101);
                    end
                    default: exp_err = 1;
                endcase
            end
        end
    endtask

    always @(posedge clkin) begin
        cyc++;
        model_step(cyc);
    end

    always @(negedge clkin) begin
        beat_t e;
        if (mon_en) begin
            chk("bank_open", 32'(bank_open), 32'(m_open));
            if (!frozen) begin
                chk("err_cmd", 32'(err_cmd), 32'(exp_err));
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missed_beat cycle %0d: got none expected beat at %0d", cyc, e.cyc);
                end
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    e = exp_q.pop_front();
                    chk("dqs_oe", 32'(ddqs_oe), 32'd1);
                    chk("dq_oe", 32'(ddq_oe), 32'(!e.pre));
                    chk("dqs_t", 32'(ddqs_t_o), e.pre ? 32'd0 : 32'(e.t));
                    chk("dqs_c", 32'(ddqs_c_o), e.pre ? 32'd1 : 32'(!e.t));
                    if (!e.pre && e.chk) chk("dq_data", 32'(ddq_o), 32'(e.d));
                end else begin
                    chk("dq_oe_idle", 32'(ddq_oe), 32'd0);
                    chk("dqs_oe_idle", 32'(ddqs_oe), 32'd0);
                end
            end
        end
    end

    initial begin
        ddq_i = 4'h0;
        forever begin
            @(negedge clkin);
            #2;
            if (dq_q.size() > 0) ddq_i = dq_q.pop_front();
            else ddq_i = 4'($urandom);
        end
    end

    task automatic tick();
        @(negedge clkin);
        #1;
    endtask

    task automatic nop(int n);
        repeat (n) begin
            tick();
            cke = 1; dcs_n = 1; dact_n = 1;
            da = 17'($urandom);
        end
    endtask

    task automatic rnop(int n);
        repeat (n) begin
            tick();
            cke    = ($urandom_range(0, 9) != 0);
            dcs_n  = 1'($urandom);
            dact_n = 1;
            da     = 17'($urandom);
            da[16:14] = 3'b111;
        end
    endtask

    task automatic cmd(bit act, logic [2:0] rcw, int b, int addr, bit a10);
        tick();
        cke    = 1;
        dcs_n  = 0;
        dact_n = ~act;
        {dbg, dba} = 4'(b);
        da = 17'($urandom);
        if (act) da[RB-1:0] = RB'(addr);
        else begin
            da[16:14]   = rcw;
            da[10]      = a10;
            da[CB-1:0]  = CB'(addr);
        end
    endtask

    task automatic act(int b, int row); cmd(1, 3'b000, b, row, 0); endtask
    task automatic rd(int b, int col, bit ap); cmd(0, 3'b101, b, col, ap); endtask
    task automatic wr(int b, int col, bit ap); cmd(0, 3'b100, b, col, ap); endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle %0d: got no finish expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        crst = 1; drst_n = 1; cke = 1; dcs_n = 1; dact_n = 1;
        da = '0; dbg = '0; dba = '0;
        repeat (3) @(negedge clkin);
        chk("rst_ddq_o", 32'(ddq_o), 32'd0);
        chk("rst_ddq_oe", 32'(ddq_oe), 32'd0);
        chk("rst_dqs_t", 32'(ddqs_t_o), 32'd0);
        chk("rst_dqs_c", 32'(ddqs_c_o), 32'd1);
        chk("rst_dqs_oe", 32'(ddqs_oe), 32'd0);
        chk("rst_bank_open", 32'(bank_open), 32'd0);
        chk("rst_err", 32'(err_cmd), 32'd0);
        #1 crst = 0;
        mon_en = 1;
        nop(2);

        // Write 1..8 then read them back from bank 5 row 3 column 8
        act(5, 3); nop(2);
        wr(5, 8, 0);
        repeat (CWL) dq_q.push_back(4'($urandom));
        for (int i = 1; i <= 8; i++) dq_q.push_back(4'(i));
        nop(CWL + 10);
        rd(5, 8, 0); nop(CL + 12);

        // Closed-bank read and double activate
        rd(2, 0, 0); nop(2);
        act(2, 7); nop(1);
        act(2, 9); nop(3);

        // Back-to-back WR at the earliest legal edge, auto-precharge read, early RD, ACT on close edge
        act(1, 2); nop(1);
        wr(1, 16, 0); nop(CWL + 7);
        wr(1, 24, 0); nop(CWL + 7);
        rd(1, 16, 1); nop(2);
        rd(1, 24, 0); nop(CL + 4);
        act(1, 5); nop(2);

        // Refresh legality
        for (int b = 8; b < 12; b++) begin act(b, b); nop(1); end
        cmd(0, 3'b001, 0, 0, 0); nop(2);
        cmd(0, 3'b010, 0, 0, 1); nop(1);
        cmd(0, 3'b001, 0, 0, 0); nop(3);

        // Async reset in the middle of a read burst, then re-read preserved data
        act(5, 3); nop(1);
        rd(5, 8, 0); nop(CL + 3);
        tick();
        crst = 1;
        model_reset();
        #1;
        chk("crst_dq_oe", 32'(ddq_oe), 32'd0);
        chk("crst_dqs_oe", 32'(ddqs_oe), 32'd0);
        chk("crst_bank_open", 32'(bank_open), 32'd0);
        tick();
        crst = 0;
        nop(2);
        act(5, 3); nop(1);
        rd(5, 8, 0); nop(3);

        // Clock-enable freeze during WAIT_RD with an ignored ACT presented
        tick();
        cke = 0; dcs_n = 0; dact_n = 0; {dbg, dba} = 4'd12; da = 17'd6;
        nop(0);
        repeat (3) tick();
        nop(CL + 12);

        // Device reset in the middle of a write burst
        act(3, 1); nop(1);
        wr(3, 0, 0); nop(CWL + 2);
        tick();
        drst_n = 0; dcs_n = 1;
        tick();
        drst_n = 1;
        nop(3);

        // Randomized traffic with random gaps, clock-enable drops and stray commands
        for (int it = 0; it < 60; it++) begin
            int b, row, col;
            b   = $urandom_range(0, 15);
            row = $urandom_range(0, 15);
            col = $urandom_range(0, 63);
            act(b, row); rnop($urandom_range(0, 2));
            wr(b, col, 0); rnop(CWL + $urandom_range(5, 10));
            rd(b, col, 1'($urandom)); rnop(CL + $urandom_range(4, 10));
            case ($urandom_range(0, 5))
                0: cmd(0, 3'b010, b, 0, 0);
                1: cmd(0, 3'b010, 0, 0, 1);
                2: cmd(0, 3'b001, 0, 0, 0);
                3: cmd(0, ($urandom % 2) ? 3'b011 : 3'b110, b, 0, 0);
                4: cmd(0, 3'b000, 0, 0, 0);
                default: cmd(1, 3'b000, $urandom_range(0, 15), $urandom_range(0, 15), 0);
            endcase
            rnop($urandom_range(1, 3));
        end
        nop(4);

        for (int w = 0; w < 200 && exp_q.size() > 0; w++) @(negedge clkin);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain cycle %0d: got %0d pending beats expected 0", cyc, exp_q.size());
        end
        mon_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
